axis_gvp_vector_generator: RTL
==============================

Name: axis_gvp_vector_generator

Overview:
- Generalized Vector Program (GVP) source for the SPM control path.
- Accepts a sequence of vector segments from the PS register bank over a valid/ready handshake.
- Integrates per-step increments into absolute scan-frame coordinates Xs, Ys, Zs and U, and drives them as AXI-Stream outputs. These are the Xs/Ys/Zs/U streams the SPM control block rotates, offsets and sums.
- Also emits step and segment strobes for the downstream data sampler.

Parameters:
- SAXIS_TDATA_WIDTH, 32, width of every coordinate stream and increment.
- DECI_WIDTH, 16, width of the per-segment decimation count.
- SEG_CNT_WIDTH, 16, width of the completed-segment counter.

Ports:
- a_clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins execution when IDLE.
- abort  in  1  one-cycle pulse; stops execution, holds position.
- home  in  1  zeroes all four accumulators; honoured only in IDLE.
- vec_dx, vec_dy, vec_dz, vec_du  in  32 each  signed per-step increments.
- vec_nsteps  in  32  unsigned step count; 0 = empty segment.
- vec_decii  in  DECI_WIDTH  clocks per step minus 1.
- vec_valid  in  1  segment offered.
- vec_ready  out  1  segment accepted on valid&ready.
- M_AXIS_Xs_tdata, M_AXIS_Ys_tdata, M_AXIS_Zs_tdata, M_AXIS_U_tdata  out  32 each  accumulated coordinates.
- M_AXIS_Xs_tvalid, M_AXIS_Ys_tvalid, M_AXIS_Zs_tvalid, M_AXIS_U_tvalid  out  1 each  constant 1.
- step_strobe  out  1  one-cycle pulse on each accumulator update.
- segment_end  out  1  one-cycle pulse when a segment completes.
- busy  out  1  high outside IDLE.
- seg_count  out  SEG_CNT_WIDTH  segments completed since start.

Behaviour:

Buffering and handshake:
- One-deep segment buffer.
- vec_ready = buffer empty and not reset.
- Accepting a segment captures all vec_* fields in that cycle.
- Segments are accepted in any state, so the host may preload before start.

State machine:
- IDLE -> LOAD on start, with buffer full.
- start with buffer empty: ignored, stay IDLE.
- LOAD: move buffer into the active registers, set step counter = nsteps and decimation counter = decii. Next state RUN if nsteps != 0, otherwise END.
- RUN: decimation counter decrements each clock. At 0:
  - add dx/dy/dz/du to the X/Y/Z/U accumulators,
  - pulse step_strobe,
  - reload decii,
  - decrement the step counter.
  - When the step counter reaches 0 in that same update, go to END.
- END: pulse segment_end, increment seg_count (wraps). Next state LOAD if buffer full, otherwise IDLE.

Timing:
- First accumulator update occurs decii+1 cycles after the LOAD cycle.
- decii=0 gives one step per clock.
- Back-to-back segments cost exactly 2 non-stepping cycles (END, LOAD).

Arithmetic:
- Accumulators use a 33-bit signed sum, saturated to [-2147483647, +2147483647]; never wrap.
- Saturation holds that axis; the step still counts.

Abort:
- abort in any non-IDLE state: go to IDLE next cycle.
- Accumulators hold, buffer is cleared.
- No segment_end pulse.
- abort wins over a simultaneous step update; that update is not applied.

Other rules:
- start while busy: ignored.
- home outside IDLE: ignored.
- home and start in the same IDLE cycle: zeroing applies first, then the LOAD transition.
- seg_count clears on start.

Reset (also mid-run), all values effective the next cycle:
- state IDLE, buffer empty, accumulators 0, all strobes 0, seg_count 0.
- busy 0, vec_ready 1, tvalid outputs 1.

Optional Feature:
- Macro: GVP_REPEAT_EN.
- With the macro defined:
  - Add input vec_repeat (16 bits), captured with the segment.
  - The segment is executed repeat+1 times; accumulators carry over between passes.
  - segment_end pulses once per pass.
  - seg_count increments only after the final pass.
  - Each pass boundary costs one cycle (END then direct re-arm of counters, no LOAD).
- Without the macro: no port, single execution per segment.

Test Plan:
1. Segment dx=100, dy=-50, dz=0, du=1, nsteps=4, decii=2, then start -> step_strobe every 3 clocks; final X=400, Y=-200, U=4; one segment_end; busy falls after END; seg_count=1.
2. Two segments preloaded/streamed: A (dx=10, n=3, decii=0), B (dx=-5, n=2, decii=0) -> X sequence 10, 20, 30, 25, 20; exactly 2 idle cycles between the last A step and the first B step; seg_count=2.
3. X preloaded near max, then dx=0x40000000, n=3 -> X saturates at 2147483647 and stays; no sign flip.
4. Abort during RUN of n=100 at step 37 -> X holds 37*dx; no segment_end; vec_ready=1 next cycle; a following start with an empty buffer is ignored.
5. Reset asserted mid-segment -> next cycle: all accumulators 0, busy 0, vec_ready 1, seg_count 0; the subsequent run starts from 0.
6. nsteps=0 segment followed by an n=1 segment -> no step_strobe for the first, two segment_end pulses total, X=dx of the second.

Source files
------------

// File: rtl/axis_gvp_vector_generator.sv
`default_nettype none
//==============================================================================
// axis_gvp_vector_generator: GVP segment sequencer, saturating Xs/Ys/Zs/U
// integrators on AXI-Stream. Optional GVP_REPEAT_EN adds per-segment repeats.
// Revision: 1.0
//==============================================================================
module axis_gvp_vector_generator #(
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int DECI_WIDTH        = 16,
  parameter int SEG_CNT_WIDTH     = 16
) (
  input  logic                                a_clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                home,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] vec_dx,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] vec_dy,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] vec_dz,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] vec_du,
  input  logic [31:0]                         vec_nsteps,
  input  logic [DECI_WIDTH-1:0]               vec_decii,
`ifdef GVP_REPEAT_EN
  input  logic [15:0]                         vec_repeat,
`endif
  input  logic                                vec_valid,
  output logic                                vec_ready,
  output logic [SAXIS_TDATA_WIDTH-1:0]        M_AXIS_Xs_tdata,
  output logic [SAXIS_TDATA_WIDTH-1:0]        M_AXIS_Ys_tdata,
  output logic [SAXIS_TDATA_WIDTH-1:0]        M_AXIS_Zs_tdata,
  output logic [SAXIS_TDATA_WIDTH-1:0]        M_AXIS_U_tdata,
  output logic                                M_AXIS_Xs_tvalid,
  output logic                                M_AXIS_Ys_tvalid,
  output logic                                M_AXIS_Zs_tvalid,
  output logic                                M_AXIS_U_tvalid,
  output logic                                step_strobe,
  output logic                                segment_end,
  output logic                                busy,
  output logic [SEG_CNT_WIDTH-1:0]            seg_count
);

  localparam int W = SAXIS_TDATA_WIDTH;
  localparam logic signed [W:0] SAT_HI = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                    buf_full;
  logic signed [W-1:0]     buf_dx, buf_dy, buf_dz, buf_du;
  logic [31:0]             buf_nsteps;
  logic [DECI_WIDTH-1:0]   buf_decii;
  logic signed [W-1:0]     act_dx, act_dy, act_dz, act_du;
  logic [DECI_WIDTH-1:0]   act_decii;
  logic [31:0]             step_cnt;
  logic [DECI_WIDTH-1:0]   deci_cnt;
  logic signed [W-1:0]     acc_x, acc_y, acc_z, acc_u;
`ifdef GVP_REPEAT_EN
  logic [15:0]             buf_repeat;
  logic [15:0]             rep_cnt;
  logic [31:0]             act_nsteps;
`endif

  logic accept, take_start, aborting, do_step, last_step;

  // 33-bit sum clamped symmetrically so an axis never wraps or flips sign
  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] d);
    logic signed [W:0] s;
    s = $signed({a[W-1], a}) + $signed({d[W-1], d});
    if (s > SAT_HI)      return SAT_HI[W-1:0];
    else if (s < SAT_LO) return SAT_LO[W-1:0];
    else                 return s[W-1:0];
  endfunction

  assign vec_ready  = !buf_full && !reset;
  assign accept     = vec_valid && vec_ready;
  assign take_start = (state == S_IDLE) && start && buf_full;
  assign aborting   = abort && (state != S_IDLE);
  assign do_step    = (state == S_RUN) && (deci_cnt == '0) && !aborting;
  assign last_step  = do_step && (step_cnt == 32'd1);

  always_ff @(posedge a_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (take_start) state_nxt = S_LOAD;
      S_LOAD: state_nxt = (buf_nsteps != '0) ? S_RUN : S_END;
      S_RUN:  if (last_step) state_nxt = S_END;
      S_END: begin
`ifdef GVP_REPEAT_EN
        if (rep_cnt != '0) state_nxt = (act_nsteps != '0) ? S_RUN : S_END;
        else               state_nxt = buf_full ? S_LOAD : S_IDLE;
`else
        state_nxt = buf_full ? S_LOAD : S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
    if (aborting) state_nxt = S_IDLE;
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      buf_full    <= 1'b0;
      acc_x       <= '0;
      acc_y       <= '0;
      acc_z       <= '0;
      acc_u       <= '0;
      step_strobe <= 1'b0;
      segment_end <= 1'b0;
      seg_count   <= '0;
    end else begin
      step_strobe <= do_step;
      segment_end <= (state == S_END) && !aborting;

      if (accept) begin
        buf_full   <= 1'b1;
        buf_dx     <= vec_dx;
        buf_dy     <= vec_dy;
        buf_dz     <= vec_dz;
        buf_du     <= vec_du;
        buf_nsteps <= vec_nsteps;
        buf_decii  <= vec_decii;
`ifdef GVP_REPEAT_EN
        buf_repeat <= vec_repeat;
`endif
      end

      if (state == S_LOAD) begin
        buf_full  <= 1'b0;
        act_dx    <= buf_dx;
        act_dy    <= buf_dy;
        act_dz    <= buf_dz;
        act_du    <= buf_du;
        act_decii <= buf_decii;
        step_cnt  <= buf_nsteps;
        deci_cnt  <= buf_decii;
`ifdef GVP_REPEAT_EN
        act_nsteps <= buf_nsteps;
        rep_cnt    <= buf_repeat;
`endif
      end

      if (state == S_IDLE && home) begin
        acc_x <= '0;
        acc_y <= '0;
        acc_z <= '0;
        acc_u <= '0;
      end

      if (take_start) seg_count <= '0;

      if (state == S_RUN) begin
        if (deci_cnt == '0) deci_cnt <= act_decii;
        else                deci_cnt <= deci_cnt - DECI_WIDTH'(1);
      end

      if (do_step) begin
        acc_x    <= sat_add(acc_x, act_dx);
        acc_y    <= sat_add(acc_y, act_dy);
        acc_z    <= sat_add(acc_z, act_dz);
        acc_u    <= sat_add(acc_u, act_du);
        step_cnt <= step_cnt - 32'd1;
      end

      if (state == S_END && !aborting) begin
`ifdef GVP_REPEAT_EN
        // another pass re-arms the counters directly, skipping LOAD
        if (rep_cnt != '0) begin
          rep_cnt  <= rep_cnt - 16'd1;
          step_cnt <= act_nsteps;
          deci_cnt <= act_decii;
        end else begin
          seg_count <= seg_count + SEG_CNT_WIDTH'(1);
        end
`else
        seg_count <= seg_count + SEG_CNT_WIDTH'(1);
`endif
      end

      // abort discards any pending segment, even one offered this cycle
      if (aborting) buf_full <= 1'b0;
    end
  end

  assign busy             = (state != S_IDLE);
  assign M_AXIS_Xs_tdata  = acc_x;
  assign M_AXIS_Ys_tdata  = acc_y;
  assign M_AXIS_Zs_tdata  = acc_z;
  assign M_AXIS_U_tdata   = acc_u;
  assign M_AXIS_Xs_tvalid = 1'b1;
  assign M_AXIS_Ys_tvalid = 1'b1;
  assign M_AXIS_Zs_tvalid = 1'b1;
  assign M_AXIS_U_tvalid  = 1'b1;

endmodule
`default_nettype wire
